// File: rtl/conv_mac_stream.sv
// conv_mac_stream
//
// Streaming multiply-accumulate stage in front of the convolution output
// FIFO. Each output is the wrapped signed sum of TAPS weight*pixel products.
// An output is started only when a FIFO slot is already reserved for it.
// Free slots are tracked as credits = capacity - in_flight.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   IN_AXIS_TDATA   [2*INW-1:INW] signed weight, [INW-1:0] signed pixel
//   IN_AXIS_TVALID  tap pair valid
//   IN_AXIS_TREADY  tap accepted this cycle when high together with TVALID
//   OUT_AXIS_TDATA  signed OUTW-bit result
//   OUT_AXIS_TVALID result valid
//   OUT_AXIS_TREADY FIFO accepts result
//   capacity        free FIFO slots (registered in the FIFO)
//
// Optional build macro CONV_MAC_RELU_EN: negative results are loaded as 0.
// The default build (macro undefined) outputs the raw signed sum.

module conv_mac_stream #(
    parameter  int INW      = 8,
    parameter  int OUTW     = 24,
    parameter  int TAPS     = 9,
    parameter  int DEPTH    = 19,
    localparam int LOGDEPTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*INW-1:0]    IN_AXIS_TDATA,
    input  logic                IN_AXIS_TVALID,
    output logic                IN_AXIS_TREADY,
    output logic [OUTW-1:0]     OUT_AXIS_TDATA,
    output logic                OUT_AXIS_TVALID,
    input  logic                OUT_AXIS_TREADY,
    input  logic [LOGDEPTH:0]   capacity
);

    localparam int TAPW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CW   = LOGDEPTH + 1;
    localparam logic [TAPW-1:0] LAST_TAP = TAPW'(TAPS - 1);

    logic                   stall;
    logic                   accept;
    logic                   first_tap;
    logic                   last_tap;
    logic                   out_hs;
    logic [CW-1:0]          credits;
    logic signed [INW-1:0]  pix;
    logic signed [INW-1:0]  wt;
    logic signed [OUTW-1:0] sum;
    logic signed [OUTW-1:0] result;

    logic [TAPW-1:0]          tap_cnt_q,   tap_cnt_d;
    logic signed [2*INW-1:0]  prod_q,      prod_d;
    logic                     p_valid_q,   p_valid_d;
    logic                     p_last_q,    p_last_d;
    logic signed [OUTW-1:0]   acc_q,       acc_d;
    logic signed [OUTW-1:0]   out_data_q,  out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic [CW-1:0]            in_flight_q, in_flight_d;
    logic                     hs_q;

    assign pix       = IN_AXIS_TDATA[INW-1:0];
    assign wt        = IN_AXIS_TDATA[2*INW-1:INW];
    assign stall     = out_valid_q && !OUT_AXIS_TREADY;
    assign credits   = capacity - in_flight_q;
    assign first_tap = (tap_cnt_q == '0);
    assign last_tap  = (tap_cnt_q == LAST_TAP);
    // Gate with reset so the stage never looks ready while held in reset.
    assign IN_AXIS_TREADY = reset && !stall && (!first_tap || (credits != '0));
    assign accept    = IN_AXIS_TVALID && IN_AXIS_TREADY;
    assign out_hs    = out_valid_q && OUT_AXIS_TREADY;

    assign OUT_AXIS_TDATA  = out_data_q;
    assign OUT_AXIS_TVALID = out_valid_q;

    // Size cast of a signed product sign-extends into the accumulator width.
    assign sum = acc_q + OUTW'(prod_q);

`ifdef CONV_MAC_RELU_EN
    assign result = sum[OUTW-1] ? '0 : sum;
`else
    assign result = sum;
`endif

    always_comb begin
        tap_cnt_d   = tap_cnt_q;
        prod_d      = prod_q;
        p_valid_d   = p_valid_q;
        p_last_d    = p_last_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_flight_d = in_flight_q;

        if (!stall) begin
            // Stage 1: register the product of the accepted tap.
            if (accept) begin
                prod_d    = (2*INW)'(wt) * (2*INW)'(pix);
                p_valid_d = 1'b1;
                p_last_d  = last_tap;
                tap_cnt_d = last_tap ? '0 : tap_cnt_q + TAPW'(1);
            end else begin
                p_valid_d = 1'b0;
            end

            // Stage 2: accumulate; the last tap of a window emits the result.
            if (p_valid_q) begin
                if (p_last_q) begin
                    out_data_d  = result;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d = sum;
                end
            end
        end

        // A handshake drops valid unless a new result loaded on this edge.
        if (out_hs && !(p_valid_q && p_last_q && !stall)) begin
            out_valid_d = 1'b0;
        end

        // hs_q delays the release so it lines up with the FIFO's capacity
        // update; credits may briefly under-report, never over-report.
        case ({accept && first_tap, hs_q})
            2'b10:   in_flight_d = in_flight_q + CW'(1);
            2'b01:   in_flight_d = in_flight_q - CW'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_cnt_q   <= '0;
            prod_q      <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_flight_q <= '0;
            hs_q        <= 1'b0;
        end else begin
            tap_cnt_q   <= tap_cnt_d;
            prod_q      <= prod_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_flight_q <= in_flight_d;
            hs_q        <= out_hs;
        end
    end

endmodule

// File: tb/tb_conv_mac_stream.sv
// Directed testbench for conv_mac_stream with a small FIFO capacity model.
module tb_conv_mac_stream;

    localparam int INW      = 8;
    localparam int OUTW     = 24;
    localparam int TAPS     = 9;
    localparam int DEPTH    = 19;
    localparam int LOGDEPTH = $clog2(DEPTH);

`ifdef CONV_MAC_RELU_EN
    localparam logic [31:0] EXP_SIGNED = 32'h0;
`else
    localparam logic [31:0] EXP_SIGNED = 32'h00FD_C480;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [2*INW-1:0]    IN_AXIS_TDATA = '0;
    logic                IN_AXIS_TVALID = 1'b0;
    logic                IN_AXIS_TREADY;
    logic [OUTW-1:0]     OUT_AXIS_TDATA;
    logic                OUT_AXIS_TVALID;
    logic                OUT_AXIS_TREADY = 1'b1;
    logic [LOGDEPTH:0]   capacity;

    int  cap_base  = 19;
    bit  fifo_hold = 1'b0;
    int  hs_cnt    = 0;
    int  hs_mark   = 0;
    bit  hs_pend   = 1'b0;
    int  cyc       = 0;
    int  n_checks  = 0;
    int  n_fail    = 0;
    int  ready_miss = 0;

    logic [OUTW-1:0] res_q[$];
    int              res_cyc[$];

    conv_mac_stream #(.INW(INW), .OUTW(OUTW), .TAPS(TAPS), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .IN_AXIS_TDATA   (IN_AXIS_TDATA),
        .IN_AXIS_TVALID  (IN_AXIS_TVALID),
        .IN_AXIS_TREADY  (IN_AXIS_TREADY),
        .OUT_AXIS_TDATA  (OUT_AXIS_TDATA),
        .OUT_AXIS_TVALID (OUT_AXIS_TVALID),
        .OUT_AXIS_TREADY (OUT_AXIS_TREADY),
        .capacity        (capacity)
    );

    always #5 clk = ~clk;

    // FIFO model: when holding, each write removes a slot one cycle later.
    assign capacity = fifo_hold ? (LOGDEPTH+1)'(cap_base - (hs_cnt - hs_mark))
                                : (LOGDEPTH+1)'(cap_base);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        hs_pend <= OUT_AXIS_TVALID && OUT_AXIS_TREADY;
        hs_cnt  <= hs_cnt + int'(hs_pend);
        if (OUT_AXIS_TVALID && OUT_AXIS_TREADY) begin
            res_q.push_back(OUT_AXIS_TDATA);
            res_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_res(input string tag, input logic [31:0] exp, output int c);
        c = -1;
        if (res_q.size() == 0) begin
            check(tag, 32'hFFFF_FFFF, exp);
        end else begin
            c = res_cyc.pop_front();
            check(tag, {8'h0, res_q.pop_front()}, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_tap(input int pix, input int wt);
        bit done;
        done = 1'b0;
        IN_AXIS_TDATA  = {8'(wt), 8'(pix)};
        IN_AXIS_TVALID = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #2;
            if (IN_AXIS_TREADY) done = 1'b1;
            else ready_miss++;
            @(posedge clk);
            #1;
        end
        if (!done) check("tap_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        IN_AXIS_TVALID = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2;
        int bad;

        // Reset state, with a tap offered and credits available.
        IN_AXIS_TVALID = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'h0, IN_AXIS_TREADY}, 32'd0);
        check("rst_out_valid", {31'h0, OUT_AXIS_TVALID}, 32'd0);
        check("rst_out_data", {8'h0, OUT_AXIS_TDATA}, 32'd0);
        IN_AXIS_TVALID = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        idle(2);

        // Reset in the middle of an output, single credit.
        cap_base = 1;
        for (int i = 0; i < 4; i++) send_tap(5, 5);
        IN_AXIS_TVALID = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_in_ready", {31'h0, IN_AXIS_TREADY}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rstmid_credit_free", {31'h0, IN_AXIS_TREADY}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) send_tap(1, 1);
        idle(6);
        check("rstmid_count", res_q.size(), 32'd1);
        pop_res("rstmid_data", 32'd9, c0);
        check("rstmid_inflight_zero", {31'h0, IN_AXIS_TREADY}, 32'd1);

        // Basic window and latency.
        cap_base = 19;
        for (int i = 0; i < 9; i++) send_tap(i + 1, 2);
        IN_AXIS_TVALID = 1'b0;
        @(negedge clk);
        check("basic_lat_early", {31'h0, OUT_AXIS_TVALID}, 32'd0);
        @(negedge clk);
        check("basic_lat", {31'h0, OUT_AXIS_TVALID}, 32'd1);
        check("basic_data", {8'h0, OUT_AXIS_TDATA}, 32'd90);
        @(posedge clk);
        #1;
        idle(3);
        check("basic_count", res_q.size(), 32'd1);
        pop_res("basic_res", 32'd90, c0);

        // Signed extremes and a mixed-sign window (sum i*(i-4) = 60).
        for (int i = 0; i < 9; i++) send_tap(-128, 127);
        for (int i = 0; i < 9; i++) send_tap(i - 4, i);
        idle(5);
        pop_res("signed_neg", EXP_SIGNED, c0);
        pop_res("signed_mixed", 32'd60, c0);

        // Back-to-back outputs.
        ready_miss = 0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 9; i++) send_tap(k + 1, 1);
        idle(5);
        check("b2b_ready_gaps", ready_miss, 32'd0);
        pop_res("b2b_res0", 32'd9, c0);
        pop_res("b2b_res1", 32'd18, c1);
        pop_res("b2b_res2", 32'd27, c2);
        check("b2b_spacing01", c1 - c0, 32'd9);
        check("b2b_spacing12", c2 - c1, 32'd9);

        // Output stall for 5 cycles while taps keep coming.
        fork
            begin
                for (int i = 0; i < 9; i++) send_tap(1, 1);
                for (int i = 0; i < 9; i++) send_tap(2, 1);
                IN_AXIS_TVALID = 1'b0;
            end
            begin
                for (int i = 0; i < 100 && !OUT_AXIS_TVALID; i++) @(negedge clk);
                check("stall_seen", {31'h0, OUT_AXIS_TVALID}, 32'd1);
                OUT_AXIS_TREADY = 1'b0;
                bad = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (OUT_AXIS_TDATA !== 24'd9 || !OUT_AXIS_TVALID || IN_AXIS_TREADY) bad++;
                end
                check("stall_hold", bad, 32'd0);
                OUT_AXIS_TREADY = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        idle(6);
        check("stall_count", res_q.size(), 32'd2);
        pop_res("stall_res0", 32'd9, c0);
        pop_res("stall_res1", 32'd18, c0);

        // Credit limit: two slots, FIFO never drains.
        hs_mark   = hs_cnt;
        cap_base  = 2;
        fifo_hold = 1'b1;
        fork
            begin
                for (int k = 0; k < 3; k++)
                    for (int i = 0; i < 9; i++) send_tap(k + 1, 3);
                IN_AXIS_TVALID = 1'b0;
            end
            begin
                for (int i = 0; i < 100 && res_q.size() < 2; i++) @(negedge clk);
                repeat (4) @(negedge clk);
                check("credit_two_out", res_q.size(), 32'd2);
                check("credit_block", {31'h0, IN_AXIS_TREADY}, 32'd0);
                fifo_hold = 1'b0;
                cap_base  = 19;
                #1;
                check("credit_release", {31'h0, IN_AXIS_TREADY}, 32'd1);
            end
        join
        idle(6);
        check("credit_count", res_q.size(), 32'd3);
        pop_res("credit_res0", 32'd27, c0);
        pop_res("credit_res1", 32'd54, c0);
        pop_res("credit_res2", 32'd81, c0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
